multiport_register_file: RTL and testbench
==========================================

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 Parameter DATA_WIDTH, 16, width of each register entry in bits.
REQ-002 Parameter ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 Parameter NUM_READ, 2, number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, 0, when 1 entry 0 is hardwired to zero.
REQ-005 Clock  input  1  single clock; all state on rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 Clear  input  1  one-cycle request to zero all entries.
REQ-008 WriteEnable  input  1  write strobe.
REQ-009 WriteAddress  input  ADDR_WIDTH  write index.
REQ-010 WriteData  input  DATA_WIDTH  write value.
REQ-011 ReadEnable  input  NUM_READ  per-port read strobe.
REQ-012 ReadAddress  input  NUM_READ*ADDR_WIDTH  packed read indices, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-013 ReadData  output  NUM_READ*DATA_WIDTH  packed registered read data, same packing.
REQ-014 ReadValid  output  NUM_READ  per-port one-cycle valid pulse.
REQ-015 Busy  output  1  high while the clear sweep runs.

Function
REQ-016 Two states: CLEAR and READY; Busy SHALL equal (state == CLEAR), decoded from state.
REQ-017 CLEAR: each cycle write zero to entry ClearCount, increment ClearCount; at ClearCount = DEPTH-1 go to READY; sweep lasts exactly DEPTH cycles.
REQ-018 READY with Clear=1: next state CLEAR, ClearCount = 0; Clear in CLEAR restarts ClearCount at 0.
REQ-019 Writes and read strobes SHALL be ignored while Busy; ReadValid stays 0 and ReadData holds.
REQ-020 READY, WriteEnable=1, Clear=0: entry WriteAddress takes WriteData at the edge.
REQ-021 Clear and WriteEnable in the same READY cycle: Clear wins, write dropped.
REQ-022 READY, ReadEnable[i]=1: ReadData port i = entry ReadAddress[i] and ReadValid[i]=1 one cycle later (latency 1).
REQ-023 ReadValid[i] SHALL be 0 in any cycle not following an accepted strobe on port i.
REQ-024 ReadData port i SHALL hold its last value when no read is accepted on port i.
REQ-025 Read and write to the same address in the same cycle: read returns the new WriteData (write-first bypass), per port independently.
REQ-026 All read ports may address the same or different entries simultaneously without stall.
REQ-027 ZERO_REG=1: writes to entry 0 discarded, no bypass for address 0, reads of entry 0 return zero.
REQ-028 ClearCount wraps from DEPTH-1 only via the state transition; no out-of-range index.

Reset
REQ-029 Reset=1 SHALL immediately force state CLEAR, ClearCount 0, ReadData all zero, ReadValid all zero, so Busy=1 during reset.
REQ-030 Storage array is not reset directly; it is zeroed by the sweep starting on the first edge after Reset falls.
REQ-031 Reset mid-sweep or mid-read aborts the operation; the pending ReadValid is dropped and the sweep restarts from entry 0.

Structure
REQ-032 Package register_file_pkg SHALL hold the state enum (CLEAR, READY) and default parameter constants.
REQ-033 Sub-module rf_clear_sequencer SHALL own state, ClearCount and Busy; storage and read ports stay in the top.

Verification (DATA_WIDTH=16, ADDR_WIDTH=6, NUM_READ=2 unless stated)
REQ-034 Release Reset -> Busy high exactly 64 cycles, then low; reading all 64 entries returns 0x0000.
REQ-035 Write 0xBEEF to 5, then ReadEnable[0] at address 5 -> next cycle ReadData port0 = 0xBEEF, ReadValid[0]=1 for one cycle.
REQ-036 Same cycle: write 0x1234 to 9, both ports read 9 -> next cycle both ports = 0x1234, both valid.
REQ-037 Write 0x5555 to 3; then Clear with write 0xAAAA to 3 same cycle -> Busy 64 cycles; then read 3 -> 0x0000.
REQ-038 Reset asserted at ClearCount=20 with a read in flight -> ReadData 0, ReadValid 0 at once; after release Busy 64 cycles.
REQ-039 ZERO_REG=1: write 0xFFFF to 0 while reading 0 -> 0x0000; later read 0 -> 0x0000.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared types and default sizing for the multiport register file.
package register_file_pkg;

   // Clear sweep / normal operation
   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } rf_state_e;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_ADDR_WIDTH = 6;
   localparam int DEF_NUM_READ   = 2;
   localparam int DEF_ZERO_REG   = 0;

endpackage

// File: rtl/rf_clear_sequencer.sv
// Owns the CLEAR/READY state and the sweep index used to zero the storage.
// Busy is decoded straight from the state register.
module rf_clear_sequencer
   import register_file_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   output logic                  busy_o,
   output logic [ADDR_WIDTH-1:0] clr_addr_o
);

   rf_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

   // State and sweep index registers; reset parks the sweep at entry 0
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: sweep one entry per cycle, leave CLEAR after the last entry
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLEAR: begin
            if (clear_i) begin
               cnt_d = '0;
            end else if (&cnt_q) begin
               state_d = READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
         end
         READY: begin
            if (clear_i) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   assign busy_o     = (state_q == CLEAR);
   assign clr_addr_o = cnt_q;

endmodule

// File: rtl/multiport_register_file.sv
// Register file with one write port, NUM_READ registered read ports,
// write-first bypass and a sequenced clear. Storage is never reset directly;
// the clear sequencer sweeps it to zero after reset or on request.
module multiport_register_file
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_READ   = DEF_NUM_READ,
   parameter int ZERO_REG   = DEF_ZERO_REG
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           clear_i,
   input  logic                           we_i,
   input  logic [ADDR_WIDTH-1:0]          waddr_i,
   input  logic [DATA_WIDTH-1:0]          wdata_i,
   input  logic [NUM_READ-1:0]            re_i,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr_i,
   output logic [NUM_READ*DATA_WIDTH-1:0] rdata_o,
   output logic [NUM_READ-1:0]            rvalid_o,
   output logic                           busy_o
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0]          mem_q [DEPTH];
   logic                           busy;
   logic [ADDR_WIDTH-1:0]          clr_addr;
   logic                           wr_acc;
   logic [NUM_READ-1:0]            rd_acc;
   logic [NUM_READ*DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [NUM_READ-1:0]            rvalid_q, rvalid_d;

   rf_clear_sequencer #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_seq (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .busy_o     (busy),
      .clr_addr_o (clr_addr)
   );

   // A write lands only in READY without a competing clear; entry 0 is
   // read-only when it is hardwired to zero
   assign wr_acc = we_i && !clear_i && !busy &&
                   !((ZERO_REG != 0) && (waddr_i == '0));
   assign rd_acc = re_i & {NUM_READ{~busy}};

   // Storage: sweep writes zero while busy, otherwise the accepted write
   always_ff @(posedge clk_i) begin
      if (busy) begin
         mem_q[clr_addr] <= '0;
      end else if (wr_acc) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read lookup per port with write-first bypass; idle ports hold their data
   always_comb begin
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] word;
      ra       = '0;
      word     = '0;
      rdata_d  = rdata_q;
      rvalid_d = rd_acc;
      for (int i = 0; i < NUM_READ; i++) begin
         ra = raddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
         if ((ZERO_REG != 0) && (ra == '0)) begin
            word = '0;
         end else if (wr_acc && (waddr_i == ra)) begin
            word = wdata_i;
         end else begin
            word = mem_q[ra];
         end
         if (rd_acc[i]) begin
            rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = word;
         end
      end
   end

   // Registered read outputs; reset drops any pending read immediately
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q  <= '0;
         rvalid_q <= '0;
      end else begin
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign busy_o   = busy;

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file. Two instances share every input:
// u_dut with ZERO_REG=0 and u_dutz with ZERO_REG=1.
module tb_multiport_register_file;

   logic        clk = 1'b0;
   logic        rst, clear, we;
   logic [5:0]  waddr;
   logic [15:0] wdata;
   logic [1:0]  re;
   logic [11:0] raddr;
   logic [31:0] rdata, rdata_z;
   logic [1:0]  rvalid, rvalid_z;
   logic        busy, busy_z;

   int ntests = 0;
   int nfail  = 0;

   typedef struct {
      logic [15:0] d;
      logic [15:0] dz;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] model [64];
   logic [15:0] last   [2];
   logic [15:0] last_z [2];

   always #5 clk = ~clk;

   multiport_register_file #(
      .DATA_WIDTH (16), .ADDR_WIDTH (6), .NUM_READ (2), .ZERO_REG (0)
   ) u_dut (
      .clk_i (clk), .rst_i (rst), .clear_i (clear), .we_i (we),
      .waddr_i (waddr), .wdata_i (wdata), .re_i (re), .raddr_i (raddr),
      .rdata_o (rdata), .rvalid_o (rvalid), .busy_o (busy)
   );

   multiport_register_file #(
      .DATA_WIDTH (16), .ADDR_WIDTH (6), .NUM_READ (2), .ZERO_REG (1)
   ) u_dutz (
      .clk_i (clk), .rst_i (rst), .clear_i (clear), .we_i (we),
      .waddr_i (waddr), .wdata_i (wdata), .re_i (re), .raddr_i (raddr),
      .rdata_o (rdata_z), .rvalid_o (rvalid_z), .busy_o (busy_z)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic outputs_hold(input string tag);
      for (int p = 0; p < 2; p++) begin
         chk({tag, "/vld"},   32'(rvalid[p]),   32'd0);
         chk({tag, "/vld_z"}, 32'(rvalid_z[p]), 32'd0);
         chk({tag, "/dat"},   32'(rdata[p*16 +: 16]),   32'(last[p]));
         chk({tag, "/dat_z"}, 32'(rdata_z[p*16 +: 16]), 32'(last_z[p]));
      end
   endtask

   task automatic reset_chk(input string tag);
      chk({tag, "/busy"},   32'(busy),     32'd1);
      chk({tag, "/busy_z"}, 32'(busy_z),   32'd1);
      chk({tag, "/vld"},    32'(rvalid),   32'd0);
      chk({tag, "/vld_z"},  32'(rvalid_z), 32'd0);
      chk({tag, "/dat"},    rdata,         32'd0);
      chk({tag, "/dat_z"},  rdata_z,       32'd0);
      for (int p = 0; p < 2; p++) begin
         last[p]   = 16'h0;
         last_z[p] = 16'h0;
      end
      for (int k = 0; k < 64; k++) model[k] = 16'h0;
   endtask

   // Count samples with busy high, starting at the current sample point
   task automatic busy_len(input string tag, input int exp);
      int n;
      n = 0;
      while (busy && n < 300) begin
         n++;
         @(posedge clk); #1;
      end
      chk(tag, 32'(n), 32'(exp));
      chk({tag, "/z"}, 32'(busy_z), 32'd0);
   endtask

   // One READY-state cycle: expectations pushed at drive, popped after the edge
   task automatic drive(input string tag, input logic c, input logic w,
                        input logic [5:0] wa, input logic [15:0] wd,
                        input logic [1:0] r, input logic [5:0] a0, input logic [5:0] a1);
      logic [5:0] a;
      exp_t       e;
      clear = c; we = w; waddr = wa; wdata = wd; re = r; raddr = {a1, a0};
      for (int p = 0; p < 2; p++) begin
         if (r[p]) begin
            a    = (p == 0) ? a0 : a1;
            e.d  = (w && !c && wa == a) ? wd : model[a];
            e.dz = (a == 6'd0) ? 16'h0 : e.d;
            sbq.push_back(e);
         end
      end
      if (w && !c) model[wa] = wd;
      if (c) for (int k = 0; k < 64; k++) model[k] = 16'h0;
      @(posedge clk); #1;
      clear = 1'b0; we = 1'b0; re = 2'b00;
      for (int p = 0; p < 2; p++) begin
         if (r[p]) begin
            if (sbq.size() == 0) begin
               ntests++;
               nfail++;
               $error("FAIL %s/sbq observed=empty expected=entry", tag);
            end else begin
               e         = sbq.pop_front();
               last[p]   = e.d;
               last_z[p] = e.dz;
            end
         end
         chk({tag, "/vld"},   32'(rvalid[p]),   32'(r[p]));
         chk({tag, "/vld_z"}, 32'(rvalid_z[p]), 32'(r[p]));
         chk({tag, "/dat"},   32'(rdata[p*16 +: 16]),   32'(last[p]));
         chk({tag, "/dat_z"}, 32'(rdata_z[p*16 +: 16]), 32'(last_z[p]));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; clear = 1'b0; we = 1'b0; waddr = '0; wdata = '0; re = '0; raddr = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_chk("rst");
      rst = 1'b0;
      busy_len("sweep_init", 64);

      // Every entry reads back zero after the initial sweep
      for (int a = 0; a < 64; a++) drive("zero", 0, 0, 6'd0, 16'h0, 2'b11, 6'(a), 6'(63 - a));

      // Single write then single read
      drive("w5", 0, 1, 6'd5, 16'hBEEF, 2'b00, 6'd0, 6'd0);
      drive("r5", 0, 0, 6'd0, 16'h0, 2'b01, 6'd5, 6'd0);
      drive("idle5", 0, 0, 6'd0, 16'h0, 2'b00, 6'd0, 6'd0);

      // Same-cycle write and dual read of that address
      drive("byp9", 0, 1, 6'd9, 16'h1234, 2'b11, 6'd9, 6'd9);

      // Distinct addresses, bypass on one port only
      drive("w10", 0, 1, 6'd10, 16'h0A0A, 2'b00, 6'd0, 6'd0);
      drive("w20", 0, 1, 6'd20, 16'h1414, 2'b00, 6'd0, 6'd0);
      drive("w63", 0, 1, 6'd63, 16'hC0DE, 2'b00, 6'd0, 6'd0);
      drive("r10_20", 0, 0, 6'd0, 16'h0, 2'b11, 6'd10, 6'd20);
      drive("r63_10", 0, 0, 6'd0, 16'h0, 2'b11, 6'd63, 6'd10);
      drive("byp11", 0, 1, 6'd11, 16'h7E57, 2'b11, 6'd10, 6'd11);
      drive("r5_9", 0, 0, 6'd0, 16'h0, 2'b10, 6'd0, 6'd5);

      // Entry 0: plain instance stores and bypasses, hardwired instance reads zero
      drive("zbyp", 0, 1, 6'd0, 16'hFFFF, 2'b11, 6'd0, 6'd0);
      drive("z0", 0, 0, 6'd0, 16'h0, 2'b11, 6'd0, 6'd0);

      // Clear beats a same-cycle write; accesses during the sweep are ignored
      drive("w3", 0, 1, 6'd3, 16'h5555, 2'b00, 6'd0, 6'd0);
      drive("r3", 0, 0, 6'd0, 16'h0, 2'b10, 6'd0, 6'd3);
      drive("clr3", 1, 1, 6'd3, 16'hAAAA, 2'b00, 6'd0, 6'd0);
      chk("clr3/busy", 32'(busy), 32'd1);
      we = 1'b1; waddr = 6'd7; wdata = 16'h7777; re = 2'b11; raddr = {6'd3, 6'd7};
      @(posedge clk); #1;
      we = 1'b0; re = 2'b00;
      outputs_hold("busy_ign");
      busy_len("sweep_clr", 63);
      drive("r3_7", 0, 0, 6'd0, 16'h0, 2'b11, 6'd3, 6'd7);
      drive("r5_63", 0, 0, 6'd0, 16'h0, 2'b11, 6'd5, 6'd63);

      // Reset in the middle of a sweep with read strobes asserted
      drive("w2", 0, 1, 6'd2, 16'h4321, 2'b00, 6'd0, 6'd0);
      drive("r2", 0, 0, 6'd0, 16'h0, 2'b01, 6'd2, 6'd0);
      drive("clr2", 1, 0, 6'd0, 16'h0, 2'b00, 6'd0, 6'd0);
      repeat (20) @(posedge clk);
      #1;
      chk("cnt20/busy", 32'(busy), 32'd1);
      re = 2'b11; raddr = {6'd2, 6'd2};
      #2 rst = 1'b1;
      #1;
      reset_chk("midrst");
      re = 2'b00;
      @(posedge clk); #1;
      rst = 1'b0;
      busy_len("sweep_rst", 64);
      chk("sbq_empty", 32'(sbq.size()), 32'd0);
      drive("r2_after", 0, 0, 6'd0, 16'h0, 2'b11, 6'd2, 6'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
